aexm_dcache_resp: RTL

- Data-side responder for the aexm core: a direct-mapped, write-through, no-write-allocate data cache.
- Consumes the core's early (precycle) and current (cycle) word addresses, the byte-lane selects and the load/store strobes.
- Returns the read word to the core's load-data input and asserts a stall while it is busy.
- Misses and all stores go to a simple request/acknowledge word memory port.

---
 rtl/aexm_dcache_resp_if.sv | 23 ++
 rtl/aexm_dcache_resp.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/aexm_dcache_resp_if.sv
// aexm data cache memory port.
// Word-wide request/acknowledge bus between the cache and memory.
interface aexm_dcache_resp_if #(
    parameter int AW = 30
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_sel;
    logic [31:0]   mem_wdat;
    logic          mem_ack;
    logic [31:0]   mem_rdat;

    modport master (
        output mem_req, mem_we, mem_addr, mem_sel, mem_wdat,
        input  mem_ack, mem_rdat
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_sel, mem_wdat,
        output mem_ack, mem_rdat
    );
endinterface

// File: rtl/aexm_dcache_resp.sv
// aexm data-side responder: direct-mapped, write-through,
// no-write-allocate cache with a request/ack word memory port.
module aexm_dcache_resp #(
    parameter int AW  = 30,
    parameter int IDX = 8
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic [AW-1:0] dc_precycle_addr,
    input  logic [AW-1:0] dc_cycle_addr,
    input  logic [3:0]    dc_sel,
    input  logic          dc_rd,
    input  logic          dc_wr,
    input  logic [31:0]   dc_wdat,
    input  logic          dc_inv,
    output logic [31:0]   dc_rdat,
    output logic          dc_busy,
    aexm_dcache_resp_if.master mem
);
    localparam int DEPTH = 1 << IDX;
    localparam int TW    = AW - IDX;

    typedef enum logic [2:0] {
        SWEEP, IDLE, REREAD, FILL, WRITE
    } state_t;

    state_t state, nextState;

    logic [TW-1:0]   tagRam [DEPTH];
    logic [3:0][7:0] dataRam [DEPTH];
    logic [DEPTH-1:0] valid;

    logic [TW-1:0]  tagQ;
    logic [31:0]    dataQ;
    logic           validQ;
    logic [IDX-1:0] ridx;
    logic [IDX-1:0] raddr;
    logic [IDX-1:0] cycIdx;
    logic [TW-1:0]  cycTag;
    logic [IDX-1:0] cnt;
    logic [31:0]    rdatQ;
    logic           done;
    logic           invPend;
    logic           isRd, isWr, hit, ackOk;
    logic           startFill, startWrite, fillWe;

    assign cycIdx = dc_cycle_addr[IDX-1:0];
    assign cycTag = dc_cycle_addr[AW-1:IDX];
    assign raddr  = (state == IDLE) ? dc_precycle_addr[IDX-1:0] : cycIdx;
    assign isWr   = dc_wr && (dc_sel != 4'h0);
    assign isRd   = dc_rd && !dc_wr;
    assign hit    = validQ && (tagQ == cycTag);
    assign ackOk  = mem.mem_ack && mem.mem_req;
    assign fillWe = (state == FILL) && ackOk && !grst;

    always_comb begin
        nextState  = state;
        dc_busy    = 1'b1;
        dc_rdat    = rdatQ;
        startFill  = 1'b0;
        startWrite = 1'b0;
        unique case (state)
            SWEEP: begin
                if (!dc_inv && cnt == '1) nextState = IDLE;
            end
            IDLE: begin
                // done marks the cycle the core consumes a finished access
                if (done) begin
                    dc_busy = 1'b0;
                    if (dc_inv) nextState = SWEEP;
                end else if (dc_inv) begin
                    nextState = SWEEP;
                end else if ((isWr || isRd) && ridx != cycIdx) begin
                    nextState = REREAD;
                end else if (isWr) begin
                    startWrite = 1'b1;
                    nextState  = WRITE;
                end else if (isRd && !hit) begin
                    startFill = 1'b1;
                    nextState = FILL;
                end else begin
                    dc_busy = 1'b0;
                    if (isRd) dc_rdat = dataQ;
                end
            end
            REREAD: nextState = dc_inv ? SWEEP : IDLE;
            FILL, WRITE: begin
                if (ackOk) nextState = (invPend || dc_inv) ? SWEEP : IDLE;
            end
            default: nextState = SWEEP;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state        <= SWEEP;
            cnt          <= '0;
            invPend      <= 1'b0;
            done         <= 1'b0;
            rdatQ        <= '0;
            mem.mem_req  <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_sel  <= '0;
            mem.mem_wdat <= '0;
        end else begin
            state <= nextState;
            if (state == SWEEP && !dc_inv) cnt <= cnt + 1'b1;
            else cnt <= '0;
            if (state == SWEEP) invPend <= 1'b0;
            else if (dc_inv && (state == FILL || state == WRITE)) invPend <= 1'b1;
            if ((state == FILL || state == WRITE) && ackOk) done <= 1'b1;
            else if (state == IDLE) done <= 1'b0;
            if (fillWe) rdatQ <= mem.mem_rdat;
            if (startFill) begin
                mem.mem_req  <= 1'b1;
                mem.mem_we   <= 1'b0;
                mem.mem_addr <= dc_cycle_addr;
                mem.mem_sel  <= 4'hF;
            end else if (startWrite) begin
                mem.mem_req  <= 1'b1;
                mem.mem_we   <= 1'b1;
                mem.mem_addr <= dc_cycle_addr;
                mem.mem_sel  <= dc_sel;
                mem.mem_wdat <= dc_wdat;
            end else if ((state == FILL || state == WRITE) && ackOk) begin
                mem.mem_req <= 1'b0;
            end
        end
    end

    // Arrays carry no reset; the sweep after reset clears the valid bits.
    always_ff @(posedge gclk) begin
        tagQ   <= tagRam[raddr];
        dataQ  <= dataRam[raddr];
        validQ <= valid[raddr];
        ridx   <= raddr;
        if (state == SWEEP) valid[cnt] <= 1'b0;
        if (fillWe) begin
            tagRam[cycIdx]  <= cycTag;
            dataRam[cycIdx] <= mem.mem_rdat;
            valid[cycIdx]   <= 1'b1;
        end
        if (startWrite && hit && !grst) begin
            for (int b = 0; b < 4; b++) begin
                if (dc_sel[b]) dataRam[cycIdx][b] <= dc_wdat[8*b +: 8];
            end
        end
    end
endmodule
